spi_bus_arbiter: RTL and testbench

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

---
 rtl/spi_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter: round-robin tie break, forced dead time between
// owners, per-grant timeout, and a combinational pin mux for the current owner.
//
// state | meaning
// IDLE  | bus free, arbitrating incoming requests
// OWN0  | requester 0 (flash reader) drives the physical bus
// OWN1  | requester 1 (SPI RAM controller) drives the physical bus
// GAP   | enforced dead time after an owner leaves, all pins parked
module spi_bus_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic clk0,
  input  logic mosi0,
  input  logic cs0_n,
  input  logic clk1,
  input  logic mosi1,
  input  logic cs1_n,
  output logic miso0,
  output logic miso1,
  output logic SPI_CLK,
  output logic SPI_MOSI,
  output logic SPI_CS0_N,
  output logic SPI_CS1_N,
  input  logic SPI_MISO,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_e        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic          last_q, last_d;
  logic          terr_q, terr_d;
  logic          own_req, own_cs_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      to_q    <= '0;
      last_q  <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    to_d     = to_q;
    last_d   = last_q;
    terr_d   = 1'b0;
    own_req  = (state_q == OWN1) ? req1 : req0;
    own_cs_n = (state_q == OWN1) ? cs1_n : cs0_n;
    unique case (state_q)
      IDLE: begin
        to_d = '0;
        // On a tie the requester that did not own the bus last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (to_q != '1) begin
          to_d = to_q + 1'b1;
        end
        if (!own_req && own_cs_n) begin
          state_d = GAP;
          gap_d   = '0;
          last_d  = (state_q == OWN1);
        end else if (TO_EN && (to_q == TO_LAST)) begin
          state_d = GAP;
          gap_d   = '0;
          last_d  = (state_q == OWN1);
          terr_d  = 1'b1;
        end
      end
      GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = (state_q == OWN0);
    gnt1      = (state_q == OWN1);
    busy      = (state_q != IDLE);
    timeout_err = terr_q;
    SPI_CLK   = 1'b0;
    SPI_MOSI  = 1'b0;
    SPI_CS0_N = 1'b1;
    SPI_CS1_N = 1'b1;
    miso0     = 1'b0;
    miso1     = 1'b0;
    case (state_q)
      OWN0: begin
        SPI_CLK   = clk0;
        SPI_MOSI  = mosi0;
        SPI_CS0_N = cs0_n;
        miso0     = SPI_MISO;
      end
      OWN1: begin
        SPI_CLK   = clk1;
        SPI_MOSI  = mosi1;
        SPI_CS1_N = cs1_n;
        miso1     = SPI_MISO;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: driver pushes the reference model's
// expected pin state every cycle, a negedge monitor pops and compares.
module tb_spi_bus_arbiter;

  localparam int GAP = 2;
  localparam int TO  = 16;

  logic clk = 1'b1;
  logic rst_n = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic clk0 = 1'b0, mosi0 = 1'b0, cs0_n = 1'b1;
  logic clk1 = 1'b0, mosi1 = 1'b0, cs1_n = 1'b1;
  logic SPI_MISO = 1'b0;
  logic gnt0, gnt1, miso0, miso1, SPI_CLK, SPI_MOSI, SPI_CS0_N, SPI_CS1_N, busy, timeout_err;

  spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .clk0(clk0), .mosi0(mosi0), .cs0_n(cs0_n), .clk1(clk1), .mosi1(mosi1), .cs1_n(cs1_n),
    .miso0(miso0), .miso1(miso1), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_CS0_N(SPI_CS0_N), .SPI_CS1_N(SPI_CS1_N), .SPI_MISO(SPI_MISO),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, how long, how much dead time remains.
  int owner;
  int gap_left;
  int held;
  int last;
  bit to_pulse;

  function void model_reset();
    owner    = -1;
    gap_left = 0;
    held     = 0;
    last     = 1;
    to_pulse = 1'b0;
  endfunction

  function void model_step();
    bit r[2];
    bit c[2];
    r[0] = req0; r[1] = req1; c[0] = cs0_n; c[1] = cs1_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    to_pulse = 1'b0;
    if (owner >= 0) begin
      held++;
      if (!r[owner] && c[owner]) begin
        last = owner; owner = -1; gap_left = GAP;
      end else if (TO != 0 && held >= TO) begin
        last = owner; owner = -1; gap_left = GAP; to_pulse = 1'b1;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (r[0] || r[1]) begin
      owner = (r[0] && r[1]) ? 1 - last : (r[0] ? 0 : 1);
      held  = 0;
    end
  endfunction

  function logic [9:0] model_outputs();
    logic g0, g1, m0, m1, sc, sm, s0, s1, bz;
    g0 = (owner == 0); g1 = (owner == 1);
    m0 = 0; m1 = 0; sc = 0; sm = 0; s0 = 1; s1 = 1;
    if (owner == 0) begin
      m0 = SPI_MISO; sc = clk0; sm = mosi0; s0 = cs0_n;
    end else if (owner == 1) begin
      m1 = SPI_MISO; sc = clk1; sm = mosi1; s1 = cs1_n;
    end
    bz = (owner >= 0) || (gap_left > 0);
    return {g0, g1, m0, m1, sc, sm, s0, s1, bz, to_pulse};
  endfunction

  function void push(input string tag);
    exp_t e;
    e.exp = model_outputs();
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // One clock: model consumes the edge, then new inputs are applied.
  task automatic tick(input bit r0, input bit c0n, input bit r1, input bit c1n,
                      input bit rs, input string tag);
    @(posedge clk);
    model_step();
    #2;
    req0 = r0; cs0_n = c0n; req1 = r1; cs1_n = c1n; rst_n = rs;
    clk0 = 1'($urandom); mosi0 = 1'($urandom);
    clk1 = 1'($urandom); mosi1 = 1'($urandom);
    SPI_MISO = 1'($urandom);
    if (!rs) model_reset();
    push(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 1, 1, tag);
  endtask

  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {gnt0, gnt1, miso0, miso1, SPI_CLK, SPI_MOSI, SPI_CS0_N, SPI_CS1_N, busy, timeout_err};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s t=%0t got {gnt0,gnt1,miso0,miso1,clk,mosi,cs0,cs1,busy,terr}=%b want %b",
                   e.tag, $time, act, e.exp);
        end
      end
    end
  end

  initial begin
    bit r0, r1, c0, c1, rs;
    #1 rst_n = 1'b0;
    model_reset();
    push("reset");
    tick(0, 1, 0, 1, 0, "reset");
    tick(0, 1, 0, 1, 1, "rst_release");
    idle(2, "idle_after_reset");

    // Single-requester transfer and release into GAP.
    tick(1, 1, 0, 1, 1, "single_req0");
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 1, 1, "xfer0");
    tick(0, 1, 0, 1, 1, "release0");
    idle(4, "gap_then_idle");

    // Simultaneous requests after reset: 0 first, then 1, then 0 again.
    tick(0, 1, 0, 1, 0, "tie_reset");
    tick(0, 1, 0, 1, 1, "tie_reset");
    tick(1, 1, 1, 1, 1, "tie_first");
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 1, 1, "tie_own0");
    tick(0, 1, 1, 1, 1, "tie_rel0");
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 0, 1, "tie_own1");
    tick(0, 1, 0, 1, 1, "tie_rel1");
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 1, 1, "tie_second");
    idle(5, "tie_done");

    // Request dropped mid-transfer: grant holds until CS rises.
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 1, "hold1");
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 1, "hold1_reqdrop");
    tick(0, 1, 0, 1, 1, "hold1_csrise");
    idle(4, "hold1_done");

    // Timeout with requester 1 pending.
    for (int i = 0; i < 24; i++) tick(1, 0, 1, 1, 1, "timeout0");
    tick(0, 1, 0, 1, 1, "timeout_rel");
    idle(4, "timeout_done");

    // MISO routing while 0 owns; CS1 stays parked.
    for (int i = 0; i < 10; i++) tick(1, 0, 1'($urandom), 1'($urandom), 1, "miso0_route");
    tick(0, 1, 0, 1, 1, "miso0_rel");
    idle(4, "miso0_done");

    // Reset mid-transfer, then re-grant.
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 1, "rst_mid_own1");
    tick(0, 1, 1, 0, 0, "rst_mid_assert");
    tick(0, 1, 1, 0, 0, "rst_mid_hold");
    tick(0, 1, 1, 0, 1, "rst_mid_release");
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 1, "rst_regrant");
    tick(0, 1, 0, 1, 1, "rst_regrant_rel");
    idle(4, "rst_done");

    // Randomized traffic with sticky requests and chip selects.
    r0 = 0; r1 = 0; c0 = 1; c1 = 1; rs = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      if ($urandom_range(0, 5) == 0) c0 = ~c0;
      if ($urandom_range(0, 5) == 0) c1 = ~c1;
      rs = ($urandom_range(0, 499) != 0);
      tick(r0, c0, r1, c1, rs, "random");
    end
    idle(4, "final_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
